rc4_decrypt: RTL and testbench

- RC4 PRGA stage. Runs after mem_shuffle (KSA) has permuted S memory.
- Reads S and the encrypted-message ROM, swaps S entries, and writes plaintext bytes to the decrypted-message RAM.
- Uses the decrypt ports of memory_handler: its S-memory address/data/wren go through the handler, and it owns S memory while mem_req is high.
- start is driven by the shuffle stage's finish level.

---
 rtl/rc4_decrypt_if.sv | 29 ++
 rtl/rc4_decrypt.sv | 147 ++++++++++++++
 tb/tb_rc4_decrypt.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_decrypt_if.sv
// Bundles the decrypt-stage control, S-memory, ROM and RAM signals.
// master = rc4_decrypt, slave = memory handler / ROM / RAM side.
interface rc4_decrypt_if;
    logic       start;
    logic       finish;
    logic       fail;
    logic       mem_req;
    logic [7:0] s_address;
    logic [7:0] s_data;
    logic       s_wren;
    logic [7:0] s_q;
    logic [4:0] rom_address;
    logic [7:0] rom_q;
    logic [4:0] ram_address;
    logic [7:0] ram_data;
    logic       ram_wren;

    modport master (
        input  start, s_q, rom_q,
        output finish, fail, mem_req, s_address, s_data, s_wren,
               rom_address, ram_address, ram_data, ram_wren
    );

    modport slave (
        output start, s_q, rom_q,
        input  finish, fail, mem_req, s_address, s_data, s_wren,
               rom_address, ram_address, ram_data, ram_wren
    );
endinterface

// File: rtl/rc4_decrypt.sv
// RC4 PRGA: swaps S entries and writes ROM^keystream plaintext to RAM; RC4_ASCII_CHECK_EN adds a plaintext filter.
// Latency: 9 cycles per byte, finish 1+9*MSG_LEN cycles after start accept; registered outputs.
// Backpressure: none; memories answer one cycle after the address, start is a level sampled only in IDLE.
module rc4_decrypt #(
    parameter int MSG_LEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    rc4_decrypt_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, RD_I, LD_I, RD_J, LD_J, WR_I, WR_J, RD_F, LD_F, WR_O, DONE
    } state_t;

    localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

    state_t     state;
    logic [7:0] i, j, k, si, sj;

`ifdef RC4_ASCII_CHECK_EN
    logic [7:0] p;
    logic       p_ok;
    assign p    = bus.s_q ^ bus.rom_q;
    assign p_ok = ((p >= 8'h61) && (p <= 8'h7A)) || (p == 8'h20);
`else
    assign bus.fail = 1'b0;
`endif

    // Outputs are loaded on the transition into the state that presents them,
    // so each state's address is on the bus for exactly that state's cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            i               <= 8'd0;
            j               <= 8'd0;
            k               <= 8'd0;
            si              <= 8'd0;
            sj              <= 8'd0;
            bus.finish      <= 1'b0;
            bus.mem_req     <= 1'b0;
            bus.s_address   <= 8'd0;
            bus.s_data      <= 8'd0;
            bus.s_wren      <= 1'b0;
            bus.rom_address <= 5'd0;
            bus.ram_address <= 5'd0;
            bus.ram_data    <= 8'd0;
            bus.ram_wren    <= 1'b0;
`ifdef RC4_ASCII_CHECK_EN
            bus.fail        <= 1'b0;
`endif
        end else begin
            bus.s_address   <= 8'd0;
            bus.s_data      <= 8'd0;
            bus.s_wren      <= 1'b0;
            bus.rom_address <= 5'd0;
            bus.ram_address <= 5'd0;
            bus.ram_data    <= 8'd0;
            bus.ram_wren    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        i             <= 8'd1;
                        j             <= 8'd0;
                        k             <= 8'd0;
                        bus.mem_req   <= 1'b1;
                        bus.s_address <= 8'd1;
`ifdef RC4_ASCII_CHECK_EN
                        bus.fail      <= 1'b0;
`endif
                        state         <= RD_I;
                    end
                end
                RD_I: state <= LD_I;
                LD_I: begin
                    si            <= bus.s_q;
                    j             <= j + bus.s_q;
                    bus.s_address <= j + bus.s_q;
                    state         <= RD_J;
                end
                RD_J: state <= LD_J;
                LD_J: begin
                    sj            <= bus.s_q;
                    bus.s_address <= i;
                    bus.s_data    <= bus.s_q;
                    bus.s_wren    <= 1'b1;
                    state         <= WR_I;
                end
                WR_I: begin
                    bus.s_address <= j;
                    bus.s_data    <= si;
                    bus.s_wren    <= 1'b1;
                    state         <= WR_J;
                end
                WR_J: begin
                    bus.s_address   <= si + sj;
                    bus.rom_address <= k[4:0];
                    state           <= RD_F;
                end
                RD_F: state <= LD_F;
                LD_F: begin
`ifdef RC4_ASCII_CHECK_EN
                    if (!p_ok) begin
                        bus.fail    <= 1'b1;
                        bus.finish  <= 1'b1;
                        bus.mem_req <= 1'b0;
                        state       <= DONE;
                    end else begin
                        bus.ram_address <= k[4:0];
                        bus.ram_data    <= p;
                        bus.ram_wren    <= 1'b1;
                        state           <= WR_O;
                    end
`else
                    bus.ram_address <= k[4:0];
                    bus.ram_data    <= bus.s_q ^ bus.rom_q;
                    bus.ram_wren    <= 1'b1;
                    state           <= WR_O;
`endif
                end
                WR_O: begin
                    if (k == LAST_K) begin
                        bus.finish  <= 1'b1;
                        bus.mem_req <= 1'b0;
                        state       <= DONE;
                    end else begin
                        k             <= k + 8'd1;
                        i             <= i + 8'd1;
                        bus.s_address <= i + 8'd1;
                        state         <= RD_I;
                    end
                end
                DONE: begin
                    // A re-run requires start to be seen low first.
                    if (!bus.start) begin
                        bus.finish <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    bus.finish  <= 1'b0;
                    bus.mem_req <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rc4_decrypt.sv
// Bench for rc4_decrypt: S/ROM memory models, a reference RC4 model feeding a
// write scoreboard, and cycle/pulse/reset/re-run checks.
module tb_rc4_decrypt;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rc4_decrypt_if bus();
    rc4_decrypt #(.MSG_LEN(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0] smem [256];
    logic [7:0] ms   [256];
    logic [7:0] rom  [32];

    typedef struct {
        logic [4:0] a;
        logic [7:0] d;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int s_pulses = 0;
    int r_pulses = 0;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Synchronous-read memories: q is the old contents one edge after the address.
    always @(posedge clk) begin
        bus.s_q   <= smem[bus.s_address];
        bus.rom_q <= rom[bus.rom_address];
        if (bus.s_wren) smem[bus.s_address] = bus.s_data;
    end

    always @(negedge clk) begin
        if (bus.s_wren) s_pulses++;
        if (bus.ram_wren) begin
            r_pulses++;
            if (sb.size() == 0) begin
                check("ram_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ram_addr", int'(bus.ram_address), int'(e.a));
                check("ram_data", int'(bus.ram_data), int'(e.d));
            end
        end
    end

    task automatic init_s();
        for (int x = 0; x < 256; x++) begin
            smem[x] = 8'(x);
            ms[x]   = 8'(x);
        end
    endtask

    // Reference RC4 PRGA on the bench's own copy of S.
    task automatic model_run(output int exp_cyc, output int exp_fail,
                             output int exp_writes, output int exp_swaps);
        logic [7:0] i, j, t, tmp, p;
        i = 8'd0;
        j = 8'd0;
        exp_cyc    = 1 + 9 * N;
        exp_fail   = 0;
        exp_writes = 0;
        exp_swaps  = 0;
        for (int k = 0; k < N; k++) begin
            i = i + 8'd1;
            j = j + ms[i];
            tmp   = ms[i];
            ms[i] = ms[j];
            ms[j] = tmp;
            exp_swaps += 2;
            t = ms[i] + ms[j];
            p = ms[t] ^ rom[k];
`ifdef RC4_ASCII_CHECK_EN
            if (!(((p >= 8'h61) && (p <= 8'h7A)) || (p == 8'h20))) begin
                exp_fail = 1;
                exp_cyc  = 1 + 9 * k + 8;
                break;
            end
`endif
            sb.push_back('{a: 5'(k), d: p});
            exp_writes++;
        end
    endtask

    task automatic wait_finish(input string tag, output int cyc);
        cyc = 0;
        for (int c = 1; c <= 500; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                check({tag, "_first_i"}, int'(bus.s_address), 1);
                check({tag, "_mem_req"}, int'(bus.mem_req), 1);
                check({tag, "_fail_clr"}, int'(bus.fail), 0);
            end
            if (bus.finish) begin
                cyc = c;
                break;
            end
        end
        if (cyc == 0) check({tag, "_timeout"}, 0, 1);
    endtask

    // Leaves start high and the DUT in DONE.
    task automatic do_run(input string tag);
        int exp_cyc, exp_fail, exp_writes, exp_swaps, cyc;
        model_run(exp_cyc, exp_fail, exp_writes, exp_swaps);
        s_pulses = 0;
        r_pulses = 0;
        @(negedge clk);
        bus.start = 1'b1;
        wait_finish(tag, cyc);
        check({tag, "_cycles"}, cyc, exp_cyc);
        check({tag, "_fail"}, int'(bus.fail), exp_fail);
        @(negedge clk);
        check({tag, "_ram_pulses"}, r_pulses, exp_writes);
        check({tag, "_s_pulses"}, s_pulses, exp_swaps);
        check({tag, "_sb_left"}, sb.size(), 0);
        check({tag, "_mem_req_done"}, int'(bus.mem_req), 0);
    endtask

    task automatic drop_start();
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic load_rom(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
        for (int x = 0; x < 32; x++) rom[x] = 8'h00;
        rom[0] = b0;
        rom[1] = b1;
        rom[2] = b2;
        rom[3] = b3;
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        init_s();
        load_rom(8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl", int'({bus.finish, bus.fail, bus.mem_req, bus.s_wren, bus.ram_wren}), 0);
        check("rst_addr", int'({bus.s_address, bus.s_data, bus.rom_address, bus.ram_address}), 0);
        check("rst_ram_data", int'(bus.ram_data), 0);
        @(negedge clk);
        rst = 1'b0;

`ifdef RC4_ASCII_CHECK_EN
        load_rom(8'h63, 8'h64, 8'h72, 8'h6F);
        do_run("ascii");
        drop_start();
        init_s();
        load_rom(8'h63, 8'h05, 8'h61, 8'h61);
        do_run("reject");
        check("reject_finish", int'(bus.finish), 1);
        drop_start();
        init_s();
        load_rom(8'h63, 8'h64, 8'h72, 8'h6F);
        do_run("after_reject");
        drop_start();
`else
        do_run("zero");
        for (int x = 0; x < 256; x++) check($sformatf("s_dump_%0d", x), int'(smem[x]), int'(ms[x]));

        // start held high in DONE must not launch another run.
        r_pulses = 0;
        repeat (20) @(negedge clk);
        check("hold_finish", int'(bus.finish), 1);
        check("hold_mem_req", int'(bus.mem_req), 0);
        check("hold_no_write", r_pulses, 0);
        @(negedge clk);
        bus.start = 1'b0;
        do_run("rerun");
        drop_start();

        init_s();
        load_rom(8'h63, 8'h64, 8'h72, 8'h6F);
        do_run("ascii");
        drop_start();

        // Reset in cycle 12 of a run.
        init_s();
        begin
            int c0, c1, c2, c3;
            model_run(c0, c1, c2, c3);
        end
        @(negedge clk);
        bus.start = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ctl", int'({bus.finish, bus.fail, bus.mem_req, bus.s_wren, bus.ram_wren}), 0);
        check("midrst_addr", int'({bus.s_address, bus.s_data, bus.rom_address, bus.ram_address}), 0);
        check("midrst_ram_data", int'(bus.ram_data), 0);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        init_s();
        load_rom(8'h00, 8'h00, 8'h00, 8'h00);
        do_run("restart");
        for (int x = 0; x < 256; x++) check($sformatf("s_dump2_%0d", x), int'(smem[x]), int'(ms[x]));
        drop_start();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
